// File: rtl/hash_output_writer.sv
// Streams a finished SHA-256 digest to memory as eight 32-bit writes, H0 first,
// paced by a single-bit ready handshake from the memory side.
module hash_output_writer #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 8
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            start,
   input  logic [ADDR_WIDTH-1:0]           output_base_address,
   input  logic [NUM_WORDS*DATA_WIDTH-1:0] hash_in,
   input  logic                            mem_ready,
   output logic                            mem_write_enable,
   output logic [ADDR_WIDTH-1:0]           mem_write_address,
   output logic [DATA_WIDTH-1:0]           mem_write_data,
   output logic                            busy,
   output logic                            done
);

   localparam int HASH_WIDTH  = NUM_WORDS * DATA_WIDTH;
   localparam int INDEX_WIDTH = $clog2(NUM_WORDS);
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } state_t;

   state_t                 state;
   logic [INDEX_WIDTH-1:0] word_index;
   logic [HASH_WIDTH-1:0]  shadow;

   // The shadow shifts left on each accept so the next word always sits
   // just below the top slot, avoiding a variable part-select.
   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         word_index        <= '0;
         shadow            <= '0;
         mem_write_enable  <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  shadow            <= hash_in;
                  word_index        <= '0;
                  mem_write_address <= output_base_address;
                  mem_write_data    <= hash_in[HASH_WIDTH-1 -: DATA_WIDTH];
                  mem_write_enable  <= 1'b1;
                  busy              <= 1'b1;
                  state             <= WRITE;
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  if (word_index == LAST_INDEX) begin
                     mem_write_enable <= 1'b0;
                     busy             <= 1'b0;
                     done             <= 1'b1;
                     state            <= DONE;
                  end else begin
                     word_index        <= word_index + 1'b1;
                     mem_write_address <= mem_write_address + 1'b1;
                     mem_write_data    <= shadow[HASH_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH];
                     shadow            <= shadow << DATA_WIDTH;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/hash_output_writer.md
# hash_output_writer

Drains a completed 256-bit SHA-256 digest to the output memory as eight sequential 32-bit word writes, H0 first. It sits at the back end of the hashing datapath, after the final compression round has been added into the running hash. It is the write-side counterpart of the message-fetch path that reads input words from memory into registered I/O. Writes are paced by a single-bit ready handshake from the memory side.

## Interface

Parameters:
- ADDR_WIDTH, 16, width of the output memory word address
- DATA_WIDTH, 32, width of one digest word
- NUM_WORDS, 8, digest words per transfer (fixed at 8 for SHA-256; only 8 is required to work)

Ports:
- clock  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clock
- start  input  1  single-cycle request to write the digest; honoured only in IDLE
- output_base_address  input  ADDR_WIDTH  address for H0; sampled with start
- hash_in  input  NUM_WORDS*DATA_WIDTH  digest; H0 = bits [255:224], H7 = bits [31:0]; sampled with start
- mem_ready  input  1  memory accepts the presented write this cycle
- mem_write_enable  output  1  registered; write request valid
- mem_write_address  output  ADDR_WIDTH  registered
- mem_write_data  output  DATA_WIDTH  registered
- busy  output  1  registered; high while a transfer is in progress
- done  output  1  registered; one-cycle pulse after the last word is accepted

## Operation

- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - On start=1, capture hash_in into an internal 256-bit shadow register and output_base_address into the address register.
  - Clear word_index (3 bits) to 0 and go to WRITE.
  - In the same edge, drive mem_write_enable=1, mem_write_data=H0, mem_write_address=base, busy=1.
- WRITE:
  - A word is accepted on any posedge where mem_write_enable=1 and mem_ready=1.
  - On accept with word_index<7: increment word_index, present the next word, address+1. mem_write_enable stays 1.
  - On accept with word_index=7: drop mem_write_enable, drop busy, set done=1, go to DONE.
  - With mem_ready=0: hold address, data and enable unchanged for any number of cycles.
- DONE: clear done and return to IDLE after exactly one cycle. A start arriving in DONE is ignored.
- start while busy=1 is ignored. The shadow register and address are not disturbed.
- Address arithmetic is modulo 2^ADDR_WIDTH: base = 0xFFFE writes 0xFFFE, 0xFFFF, 0x0000 … 0x0005.
- hash_in and output_base_address may change freely after the start cycle without affecting the transfer.
- Reset values: state=IDLE, word_index=0, mem_write_enable=0, mem_write_address=0, mem_write_data=0, busy=0, done=0, shadow register=0.
- Reset has priority over everything. Reset in WRITE aborts the transfer; all outputs are at their reset values the cycle after the reset edge, and no further writes are issued.

## Timing

- start sampled at edge T → first write presented in the cycle after T.
- With mem_ready held at 1: words accepted at edges T+1 … T+8. done is high, and busy and mem_write_enable are low, in the cycle after T+8. A new start is honoured from edge T+10.
- Each mem_ready=0 cycle during WRITE adds exactly one cycle of latency.
- mem_ready is ignored when mem_write_enable=0.
- No combinational path from any input to any output.

## Test plan

- Basic transfer:
  - Stimulus: reset, then start with base=0x0100, hash_in = SHA-256("abc") = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, mem_ready=1.
  - Response: writes 0x0100←ba7816bf … 0x0107←f20015ad on consecutive cycles; done pulses once for one cycle at T+9.
- Backpressure:
  - Stimulus: same transfer with mem_ready=0 on the cycles presenting words 0, 3 and 7.
  - Response: each of those words is held stable for exactly one extra cycle; eight writes total; done delayed by 3 cycles.
- Address wrap:
  - Stimulus: base=0xFFFD.
  - Response: addresses 0xFFFD, 0xFFFE, 0xFFFF, 0x0000 … 0x0004.
- Ignored start:
  - Stimulus: pulse start with a different hash and base during word 4, and again in the DONE cycle.
  - Response: original transfer completes unchanged; no second transfer begins.
- Input changes after start:
  - Stimulus: change hash_in to all-ones the cycle after start.
  - Response: written data still equals the captured digest.
- Reset mid-transfer:
  - Stimulus: assert reset after word 2 is accepted.
  - Response: the next cycle has enable=0, busy=0, done=0, address=0, data=0; no further writes. A subsequent start performs a full 8-word transfer from H0.
